// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between pipeline writeback and a long-latency result FIFO
// Ports: clk/rst; wb_* pipeline writeback request; lu_* long-latency push (lu_ready back);
// rsv_* scoreboard reservation; q_reg*/q_busy* RAW queries; wb_stall starvation stall;
// rf_* registered write port; err sticky protocol violation.
module regfile_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_reg,
  input  logic [4:0]  q_reg1,
  input  logic [4:0]  q_reg2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    mem_reg  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic [31:0]   busy, set_mask, clr_mask;
  logic          src_fifo, empty, push, pop, wb_grant;
  assign empty    = count == '0;
  assign lu_ready = !rst && (count < (AW + 1)'(DEPTH));
  assign wb_stall = !rst && (starve >= SW'(STARVE_MAX));
  assign push     = lu_valid && lu_ready;
  assign pop      = !empty && (wb_stall || !wb_valid);
  assign wb_grant = wb_valid && !wb_stall;
  assign set_mask = (rsv_valid && rsv_reg != 5'd0) ? 32'd1 << rsv_reg : '0;
  // only FIFO-sourced commits release a reservation; pipeline writes never reserve
  assign clr_mask = (rf_we && src_fifo) ? 32'd1 << rf_waddr : '0;
  assign q_busy1  = busy[q_reg1];
  assign q_busy2  = busy[q_reg2];
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wp]  <= lu_reg;
      mem_data[wp] <= lu_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      starve   <= '0;
      busy     <= '0;
      src_fifo <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count    <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      starve   <= (pop || empty) ? '0 : starve + 1'b1;
      rf_we    <= pop ? mem_reg[rp] != 5'd0 : wb_grant && wb_reg != 5'd0;
      rf_waddr <= pop ? mem_reg[rp] : wb_reg;
      rf_wdata <= pop ? mem_data[rp] : wb_data;
      src_fifo <= pop;
      // set after clear so a same-edge reserve of a retiring register wins
      busy     <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
      err      <= err | (wb_valid && wb_stall) | (|(set_mask & busy & ~clr_mask));
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid, rsv_valid;
  logic [4:0]  wb_reg, lu_reg, rsv_reg, q_reg1, q_reg2;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, q_busy1, q_busy2, wb_stall, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int vectors = 0;
  int miscompares = 0;
  regfile_write_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
    rsv_valid = 0; rsv_reg = 0;
  endtask
  initial begin
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'($urandom); wb_reg = 5'($urandom); wb_data = $urandom;
      lu_valid = 1'($urandom); lu_reg = 5'($urandom); lu_data = $urandom;
      rsv_valid = 1'($urandom); rsv_reg = 5'($urandom);
      q_reg1 = 5'($urandom); q_reg2 = 5'($urandom);
      tick();
    end
    idle();
    q_reg1 = 5'd3; q_reg2 = 5'd17;
    #1;
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_waddr", 32'(rf_waddr), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wb_stall", 32'(wb_stall), 0);
    chk("rst_lu_ready", 32'(lu_ready), 0);
    chk("rst_q_busy1", 32'(q_busy1), 0);
    chk("rst_q_busy2", 32'(q_busy2), 0);
    rst = 0;
    tick();
    chk("post_rst_lu_ready", 32'(lu_ready), 1);
    wb_valid = 1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("wb_we", 32'(rf_we), 1);
    chk("wb_waddr", 32'(rf_waddr), 5);
    chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
    wb_valid = 1; wb_reg = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("wb_x0_we", 32'(rf_we), 0);
    rsv_valid = 1; rsv_reg = 5'd7;
    tick();
    idle();
    q_reg1 = 5'd7;
    #1;
    chk("rsv7_busy", 32'(q_busy1), 1);
    lu_valid = 1; lu_reg = 5'd7; lu_data = 32'h1234;
    tick();
    idle();
    chk("ll_pop_cycle_we", 32'(rf_we), 0);
    chk("ll_pop_cycle_busy", 32'(q_busy1), 1);
    tick();
    chk("ll_we", 32'(rf_we), 1);
    chk("ll_waddr", 32'(rf_waddr), 7);
    chk("ll_wdata", rf_wdata, 32'h1234);
    chk("ll_busy_still", 32'(q_busy1), 1);
    tick();
    chk("ll_busy_clear", 32'(q_busy1), 0);
    chk("ll_we_after", 32'(rf_we), 0);
    rsv_valid = 1; rsv_reg = 5'd9;
    tick();
    idle();
    lu_valid = 1; lu_reg = 5'd9; lu_data = 32'h99;
    tick();
    idle();
    tick();
    chk("race_we", 32'(rf_we), 1);
    chk("race_waddr", 32'(rf_waddr), 9);
    rsv_valid = 1; rsv_reg = 5'd9;
    tick();
    idle();
    q_reg2 = 5'd9;
    #1;
    chk("race_busy", 32'(q_busy2), 1);
    chk("race_err", 32'(err), 0);
    rsv_valid = 1; rsv_reg = 5'd9;
    tick();
    idle();
    chk("dup_rsv_err", 32'(err), 1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_clears_err", 32'(err), 0);
    chk("rst_clears_busy", 32'(q_busy2), 0);
    for (int i = 0; i <= 10; i++) begin
      lu_valid = i < 10; lu_reg = 5'(10 + i); lu_data = 32'h100 + 32'(i);
      #1;
      if (i < 10) chk("wrap_lu_ready", 32'(lu_ready), 1);
      tick();
      if (i >= 1) begin
        chk("wrap_we", 32'(rf_we), 1);
        chk("wrap_waddr", 32'(rf_waddr), 32'(10 + i - 1));
        chk("wrap_wdata", rf_wdata, 32'h100 + 32'(i - 1));
      end
    end
    idle();
    tick();
    chk("wrap_no_dup", 32'(rf_we), 0);
    for (int k = 0; k < 5; k++) begin
      wb_valid = 1; wb_reg = 5'd3; wb_data = 32'(k);
      lu_valid = 1; lu_reg = 5'(20 + k); lu_data = 32'h200 + 32'(k);
      #1;
      chk("cont_lu_ready", 32'(lu_ready), k < 4 ? 1 : 0);
      chk("cont_stall_low", 32'(wb_stall), 0);
      tick();
    end
    lu_valid = 0;
    wb_valid = 1; wb_reg = 5'd3; wb_data = 32'hBAD;
    #1;
    chk("cont_wb_write", rf_wdata, 4);
    chk("cont_stall", 32'(wb_stall), 1);
    chk("cont_err_before", 32'(err), 0);
    tick();
    idle();
    chk("stall_drain_we", 32'(rf_we), 1);
    chk("stall_drain_waddr", 32'(rf_waddr), 20);
    chk("stall_drain_wdata", rf_wdata, 32'h200);
    chk("stall_err", 32'(err), 1);
    chk("stall_released", 32'(wb_stall), 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("drain_waddr", 32'(rf_waddr), 32'(20 + k));
      chk("drain_wdata", rf_wdata, 32'h200 + 32'(k));
    end
    tick();
    chk("drain_empty_we", 32'(rf_we), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback and long-latency units (loads, FPU, divider). Long-latency results are buffered in a small FIFO and drained in cycles when the pipeline does not write. A 32-entry busy scoreboard lets decode stall on RAW hazards against outstanding long-latency destinations. The block sits between writeback and the register file's `RegWrite`/`WriteReg`/`WriteData` inputs.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.
- `STARVE_MAX`, 4: pipeline-write cycles a non-empty FIFO may wait before forcing a drain.
- `clk` in 1: clock; all state updates on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `wb_valid` in 1: pipeline writeback request.
- `wb_reg` in 5: writeback destination register.
- `wb_data` in 32: writeback data.
- `lu_valid` in 1: long-latency result valid.
- `lu_ready` out 1: FIFO can accept a long-latency result.
- `lu_reg` in 5: long-latency destination register.
- `lu_data` in 32: long-latency data.
- `rsv_valid` in 1: a long-latency op issued this cycle.
- `rsv_reg` in 5: destination register being reserved.
- `q_reg1`, `q_reg2` in 5 each: registers that decode is about to read.
- `q_busy1`, `q_busy2` out 1 each: combinational busy bit for the matching query.
- `wb_stall` out 1: pipeline must not assert `wb_valid` this cycle.
- `rf_we` out 1: register file write enable (registered).
- `rf_waddr` out 5: register file write address (registered).
- `rf_wdata` out 32: register file write data (registered).
- `err` out 1: sticky protocol-violation flag.

## Operation
- **FIFO.**
  - Push on `lu_valid && lu_ready`.
  - `lu_ready = !rst && (count < DEPTH)`, where `count` is the registered occupancy before any pop in the current cycle.
  - Push and pop may occur in the same cycle; when both occur, `count` is unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Grant**, decided each cycle:
  - If `wb_stall` is set and the FIFO is non-empty: pop the head to the write port.
  - Else if `wb_valid`: grant the pipeline.
  - Else if the FIFO is non-empty: pop the head.
  - Else: idle.
- **Write port.**
  - The granted request is registered into `rf_*` at the next edge.
  - A request with destination 0 is consumed but gives `rf_we = 0`; an x0 FIFO entry is still popped.
- **Starvation.**
  - The counter `starve` increments on each edge where the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - `wb_stall = (starve >= STARVE_MAX)`.
  - `wb_valid` while `wb_stall = 1` is dropped and sets `err`.
- **Scoreboard** (`busy[31:0]`, bit 0 always 0):
  - Set: on `rsv_valid` with `rsv_reg != 0`.
  - Clear: the bit for `rf_waddr` clears at the edge where `rf_we = 1` and the registered source flag says FIFO. This is the same edge on which the register file commits the write.
  - A set and a clear of the same register on the same edge leave the bit set (set wins).
  - `rsv_valid` on a register that is already busy, and not being cleared on that edge, sets `err`. Decode must stall on `q_busy` before reserving.
  - `q_busyN = busy[q_regN]`. A query of 0 always returns 0.
- **Pipeline writes** never touch the scoreboard.
- **Reset** (synchronous, dominates all other updates):
  - `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`.
  - FIFO empty, `count = 0`, `busy = 0`, `starve = 0`.
  - `wb_stall = 0`, `err = 0`, `lu_ready = 0` while `rst` is high.
  - Reset mid-operation discards FIFO contents and reservations.

## Timing
- Pipeline write: `wb_valid` in cycle N gives `rf_we = 1` in cycle N+1. The register file holds the data from cycle N+2.
- Long-latency write, best case: push at the end of cycle N, pop in cycle N+1, `rf_we = 1` in cycle N+2. `q_busy` falls in cycle N+3.
- `lu_ready` is first high in the cycle after `rst` deasserts.
- Worst-case drain delay for the FIFO head is STARVE_MAX+1 cycles of continuous `wb_valid`.
- Throughput: at most one register file write per cycle.

## Test plan
- **Reset.** Hold `rst` 2 cycles with random inputs -> all outputs 0, including `lu_ready` and `q_busy*`. One cycle after release, `lu_ready = 1`.
- **Pipeline write.** `wb_valid`, reg 5, data 0xDEADBEEF -> next cycle `rf_we = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`. Same request with reg 0 -> `rf_we` stays 0.
- **Long-latency write.**
  - `rsv` reg 7 -> `q_busy1 = 1` for `q_reg1 = 7` from the next cycle.
  - Push reg 7, data 0x1234 with `wb` idle -> `rf_we` for reg 7 two cycles after the push.
  - `q_busy1` clears one cycle after that write.
- **Contention and starvation** (`DEPTH = 4`, `STARVE_MAX = 4`).
  - Continuous `wb_valid` plus 5 back-to-back pushes -> `lu_ready` low after 4 accepted pushes.
  - `wb_stall` high after 4 starved edges; the FIFO head is then written.
  - A `wb_valid` asserted during `wb_stall` sets `err`.
- **Scoreboard races.**
  - Reserve reg 9 on the same edge as its FIFO write clears -> reg 9 remains busy, `err = 0`.
  - Reserve reg 9 again while it is busy -> `err = 1` and stays set until reset.
- **Wrap-around.** 10 push/pop pairs through `DEPTH = 4` with distinct data (0x100+i) -> writes emerge in push order, with no loss or duplication.
